// File: rtl/imem_responder.sv
// Instruction-memory responder: a word-addressed program store with a side
// load port and a fixed-latency fetch port. Fetches are accepted one at a time.
// The next fetch may be accepted in the cycle its predecessor's response is
// presented. Misaligned or out-of-range fetches return ERR_DATA flagged as an
// error.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ERR_DATA    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic        imem_valid,
  output logic [31:0] imem_data,
  output logic        imem_err,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic [31:0] req_count
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_M1 = CW'(LATENCY - 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic [31:0]   data_q, data_d;
  logic          err_q, err_d;
  logic [31:0]   pend_data_q, pend_data_d;
  logic          pend_err_q, pend_err_d;
  logic [31:0]   req_count_q, req_count_d;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          rd_bad;
  logic          wr_oob;
  logic          accept;
  logic          ready;
  logic          unused_load_lsbs;

  // Any address bit above the array span marks the word as out of range.
  assign rd_idx           = imem_addr[AW+1:2];
  assign wr_idx           = load_addr[AW+1:2];
  assign rd_bad           = (imem_addr[1:0] != 2'b00) || (|imem_addr[31:AW+2]);
  assign wr_oob           = |load_addr[31:AW+2];
  assign unused_load_lsbs = ^load_addr[1:0];

  // Program-load write port; active in every state, including during reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset branch on purpose: reset must not
    // erase a loaded program, and a resettable array cannot map onto RAM.
    if (load_we && !wr_oob) begin
      mem[wr_idx] <= load_data;
    end
  end

  // Handshake, latency countdown and response staging.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    err_d       = err_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    req_count_d = req_count_q;

    ready  = !reset && ((state_q == ST_IDLE) || valid_q);
    accept = imem_req && ready;

    if (accept) begin
      // Array is read combinationally before the edge, so a same-cycle load
      // write to this word is not seen by this fetch.
      state_d     = ST_BUSY;
      cnt_d       = LAT_M1;
      valid_d     = (LATENCY == 1);
      pend_data_d = rd_bad ? ERR_DATA : mem[rd_idx];
      pend_err_d  = rd_bad;
      req_count_d = req_count_q + 32'd1;
    end else if (state_q == ST_BUSY) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d   = cnt_q - 1'b1;
        valid_d = (cnt_q == CW'(1));
      end
    end

    // Response registers only move when a response is presented.
    if (valid_d) begin
      data_d = pend_data_d;
      err_d  = pend_err_d;
    end
  end

  // State register with synchronous reset; discards any fetch in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      pend_data_q <= '0;
      pend_err_q  <= 1'b0;
      req_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      err_q       <= err_d;
      pend_data_q <= pend_data_d;
      pend_err_q  <= pend_err_d;
      req_count_q <= req_count_d;
    end
  end

  assign imem_ready = ready;
  assign imem_valid = valid_q;
  assign imem_data  = data_q;
  assign imem_err   = err_q;
  assign req_count  = req_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances with LATENCY 1, 2 and 3 share one
// stimulus stream. A reference model predicts readiness, counts and responses;
// a monitor matches presented responses against per-instance queues.
module tb_imem_responder;

  localparam int          DEPTH = 1024;
  localparam int          NI    = 3;
  localparam logic [31:0] ERRD  = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        load_we;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rdy [NI];
  logic        vld [NI];
  logic [31:0] dat [NI];
  logic        er  [NI];
  logic [31:0] cnt [NI];

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    imem_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (g + 1),
      .ERR_DATA   (ERRD)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ready(rdy[g]),
      .imem_valid(vld[g]),
      .imem_data (dat[g]),
      .imem_err  (er[g]),
      .load_we   (load_we),
      .load_addr (load_addr),
      .load_data (load_data),
      .req_count (cnt[g])
    );
  end

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [NI][$];
  logic [31:0] mem_m [DEPTH];
  int          due_m [NI];
  logic [31:0] count_m [NI];
  logic [31:0] last_data [NI];
  logic        last_err [NI];
  int          cyc    = 0;
  bit          mon_en = 1'b0;
  int          n_vec  = 0;
  int          n_err  = 0;

  task automatic check(input string name, input int inst,
                       input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s latency=%0d cycle=%0d: got %h, wanted %h",
               name, inst + 1, cyc, act, want);
    end
  endtask

  // One clock cycle of stimulus; the model decides what each instance must do.
  task automatic step(input bit rq, input logic [31:0] a, input bit we,
                      input logic [31:0] la, input logic [31:0] ld, input bit rs);
    exp_t e;
    bit   free;
    imem_req  = rq;
    imem_addr = a;
    load_we   = we;
    load_addr = la;
    load_data = ld;
    reset     = rs;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      // Free when nothing is outstanding or its answer is being delivered now.
      free = !rs && (due_m[i] < 0 || due_m[i] == cyc);
      check("ready", i, 32'(rrdy(i)), 32'(free));
      check("req_count", i, cnt[i], count_m[i]);
      if (due_m[i] == cyc) due_m[i] = -1;
      if (rs) begin
        due_m[i]   = -1;
        count_m[i] = 32'd0;
      end else if (rq && free) begin
        e.due  = cyc + i + 1;
        e.err  = (a % 4 != 0) || (a / 4 >= DEPTH);
        e.data = e.err ? ERRD : mem_m[int'(a / 4)];
        sb[i].push_back(e);
        due_m[i]   = e.due;
        count_m[i] = count_m[i] + 32'd1;
      end
    end
    if (we && (la / 4 < DEPTH)) mem_m[int'(la / 4)] = ld;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic rrdy(input int i);
    return rdy[i];
  endfunction

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Response monitor: pops and compares whenever an instance presents data.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        if (vld[i]) begin
          if (sb[i].size() == 0) begin
            check("spurious_valid", i, 32'(vld[i]), 32'd0);
          end else begin
            e = sb[i].pop_front();
            check("resp_cycle", i, 32'(cyc), 32'(e.due));
            check("resp_data", i, dat[i], e.data);
            check("resp_err", i, 32'(er[i]), 32'(e.err));
            last_data[i] = e.data;
            last_err[i]  = e.err;
          end
        end else begin
          if (sb[i].size() != 0 && sb[i][0].due <= cyc) begin
            check("missing_valid", i, 32'(vld[i]), 32'd1);
            e = sb[i].pop_front();
          end
          check("hold_data", i, dat[i], last_data[i]);
          check("hold_err", i, 32'(er[i]), 32'(last_err[i]));
        end
        if (reset) begin
          sb[i].delete();
          last_data[i] = 32'd0;
          last_err[i]  = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] la;
    int          kind;
    reset     = 1'b1;
    imem_req  = 1'b0;
    imem_addr = 32'd0;
    load_we   = 1'b0;
    load_addr = 32'd0;
    load_data = 32'd0;
    for (int i = 0; i < NI; i++) begin
      due_m[i]     = -1;
      count_m[i]   = 32'd0;
      last_data[i] = 32'd0;
      last_err[i]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Program load while reset is held: loads must be honoured.
    for (int w = 0; w < DEPTH; w++) step(1'b0, 32'd0, 1'b1, 32'(w * 4), $urandom, 1'b1);
    step(1'b0, 32'd0, 1'b1, 32'h14, 32'hDEAD_BEEF, 1'b1);

    // First cycle out of reset: aligned fetch of word 5.
    step(1'b1, 32'h14, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(4);

    // Misaligned and out-of-range fetches.
    step(1'b1, 32'h16, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(4);
    step(1'b1, 32'h0000_1000, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(4);

    // Request held high across three addresses.
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(4);

    // Load after acceptance must not leak into the in-flight response.
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 32'h0, 32'h1111_1111, 1'b0);
    idle(5);
    step(1'b1, 32'h0, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(5);

    // Same-cycle load and fetch of one word returns the old contents.
    step(1'b1, 32'h40, 1'b1, 32'h40, 32'hCAFE_F00D, 1'b0);
    idle(5);

    // Reset one cycle after acceptance discards the fetch.
    step(1'b1, 32'h20, 1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'd0, 32'd0, 1'b1);
    idle(4);
    step(1'b1, 32'h14, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(5);

    // Counter wrap: preset to all-ones, then accept one more.
    force gen_dut[0].u_dut.req_count_q = 32'hFFFF_FFFF;
    force gen_dut[1].u_dut.req_count_q = 32'hFFFF_FFFF;
    force gen_dut[2].u_dut.req_count_q = 32'hFFFF_FFFF;
    for (int i = 0; i < NI; i++) count_m[i] = 32'hFFFF_FFFF;
    idle(1);
    release gen_dut[0].u_dut.req_count_q;
    release gen_dut[1].u_dut.req_count_q;
    release gen_dut[2].u_dut.req_count_q;
    idle(1);
    step(1'b1, 32'h4, 1'b0, 32'd0, 32'd0, 1'b0);
    idle(5);

    // Randomized traffic: fetches, loads (some dropped), occasional reset.
    for (int n = 0; n < 1500; n++) begin
      kind = $urandom_range(0, 9);
      a    = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      else if (kind == 9) a = $urandom | 32'h0000_1000;
      la = 32'($urandom_range(0, DEPTH - 1)) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) la = la | 32'h0010_0000;
      step($urandom_range(0, 2) != 0, a, $urandom_range(0, 3) == 0, la, $urandom,
           $urandom_range(0, 99) == 0);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
